// File: rtl/pe_array_seq.sv
// pe_array_seq: sequencer for an N x N systolic array of multiply-accumulate
// processing elements. On start it clears the PE accumulators, streams skewed
// per-lane read enables and k-indices to the A-row / B-column operand buffers,
// waits for the array to drain, then pulses done together with a capture strobe.
//
// Optional feature: define PE_ARRAY_SEQ_ABORT_EN to add the abort/aborted
// ports, which cancel an operation in CLEAR, FEED or DRAIN.
module pe_array_seq #(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   output logic              busy,
   output logic              pe_clr,
   output logic [N-1:0]      lane_en,
   output logic [N*KW-1:0]   lane_idx,
   output logic              capture,
`ifdef PE_ARRAY_SEQ_ABORT_EN
   output logic              done,
   input  logic              abort,
   output logic              aborted
`else
   output logic              done
`endif
);

   // Counter is wide enough that K+N-2 never wraps for any KW-bit K and N <= 16.
   localparam int CW = KW + 5;
   localparam logic [CW-1:0] N_C = CW'(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [KW-1:0]       k_q, k_d;
   logic                busy_q, busy_d;
   logic                pe_clr_q, pe_clr_d;
   logic [N-1:0]        lane_en_q, lane_en_d;
   logic [N*KW-1:0]     lane_idx_q, lane_idx_d;
   logic                capture_q, capture_d;
   logic                done_q, done_d;
   logic                abort_hit;
   logic [CW-1:0]       feed_last;
   logic [CW-1:0]       rel_t;
`ifdef PE_ARRAY_SEQ_ABORT_EN
   logic                aborted_q, aborted_d;
`endif

   // Last feed step: lane N-1 consumes its final operand at t = K+N-2.
   assign feed_last = CW'(k_q) + N_C - CW'(2);

   // Next-state and next-output logic; outputs are derived from the next state
   // so that every output comes straight from a register.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      lane_en_d  = '0;
      lane_idx_d = '0;
      rel_t      = '0;
`ifdef PE_ARRAY_SEQ_ABORT_EN
      abort_hit  = abort && (state_q inside {S_CLEAR, S_FEED, S_DRAIN});
`else
      abort_hit  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               k_d     = k_len;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = (k_q == '0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            if (cnt_q == feed_last) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            // N-1 cycles of operand propagation plus one final accumulate.
            if (cnt_q == N_C - CW'(1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (abort_hit) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      // Skewed schedule: lane i is live for K steps starting at t = i.
      if (state_d == S_FEED) begin
         for (int i = 0; i < N; i++) begin
            rel_t = cnt_d - CW'(i);
            if ((cnt_d >= CW'(i)) && (rel_t < CW'(k_d))) begin
               lane_en_d[i]             = 1'b1;
               lane_idx_d[i*KW +: KW]   = rel_t[KW-1:0];
            end
         end
      end

      busy_d    = (state_d != S_IDLE);
      pe_clr_d  = (state_d == S_CLEAR) || abort_hit;
      capture_d = (state_d == S_DONE);
      done_d    = (state_d == S_DONE);
`ifdef PE_ARRAY_SEQ_ABORT_EN
      aborted_d = abort_hit;
`endif
   end

   // State, counter, latched K and all outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: only a handful of control flops here, so all of them are reset;
      // sequential state always uses non-blocking assignment.
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         pe_clr_q   <= 1'b0;
         lane_en_q  <= '0;
         lane_idx_q <= '0;
         capture_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef PE_ARRAY_SEQ_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
         pe_clr_q   <= pe_clr_d;
         lane_en_q  <= lane_en_d;
         lane_idx_q <= lane_idx_d;
         capture_q  <= capture_d;
         done_q     <= done_d;
`ifdef PE_ARRAY_SEQ_ABORT_EN
         aborted_q  <= aborted_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign pe_clr   = pe_clr_q;
   assign lane_en  = lane_en_q;
   assign lane_idx = lane_idx_q;
   assign capture  = capture_q;
   assign done     = done_q;
`ifdef PE_ARRAY_SEQ_ABORT_EN
   assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// Testbench for pe_array_seq (N=4, KW=8): table-driven check of a K=4 run plus
// hand-written sequences for K=0, back-to-back starts, reset mid-run, k_len
// changes while busy and (when PE_ARRAY_SEQ_ABORT_EN is defined) abort.
module tb_pe_array_seq;

   localparam int N  = 4;
   localparam int KW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [KW-1:0]     k_len;
   logic              busy;
   logic              pe_clr;
   logic [N-1:0]      lane_en;
   logic [N*KW-1:0]   lane_idx;
   logic              capture;
   logic              done;
`ifdef PE_ARRAY_SEQ_ABORT_EN
   logic              abort;
   logic              aborted;
`endif

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic              busy;
      logic              pe_clr;
      logic [N-1:0]      en;
      logic [N*KW-1:0]   idx;
      logic              done;
   } vec_t;

   vec_t run_tab [1:14];

   pe_array_seq #(.N(N), .KW(KW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .busy     (busy),
      .pe_clr   (pe_clr),
      .lane_en  (lane_en),
      .lane_idx (lane_idx),
      .capture  (capture),
`ifdef PE_ARRAY_SEQ_ABORT_EN
      .done     (done),
      .abort    (abort),
      .aborted  (aborted)
`else
      .done     (done)
`endif
   );

   always #5 clk = ~clk;

   // {busy, pe_clr, lane_en, lane_idx, capture, done}
   function automatic logic [39:0] pack(input logic b, input logic c, input logic [N-1:0] e,
                                        input logic [N*KW-1:0] x, input logic cap, input logic d);
      return {b, c, e, x, cap, d};
   endfunction

   function automatic logic [39:0] obs();
      return {busy, pe_clr, lane_en, lane_idx, capture, done};
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present start for one edge; returns in cycle 1 of the new operation.
   task automatic begin_run(input logic [KW-1:0] k);
      k_len = k;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // Expected K=4 schedule, cycles 1..14.
      for (int c = 1; c <= 14; c++) begin
         run_tab[c].busy   = (c <= 13);
         run_tab[c].pe_clr = (c == 1);
         run_tab[c].en     = '0;
         run_tab[c].idx    = '0;
         run_tab[c].done   = (c == 13);
      end
      run_tab[2].en = 4'b0001; run_tab[2].idx = 32'h0000_0000;
      run_tab[3].en = 4'b0011; run_tab[3].idx = 32'h0000_0001;
      run_tab[4].en = 4'b0111; run_tab[4].idx = 32'h0000_0102;
      run_tab[5].en = 4'b1111; run_tab[5].idx = 32'h0001_0203;
      run_tab[6].en = 4'b1110; run_tab[6].idx = 32'h0102_0300;
      run_tab[7].en = 4'b1100; run_tab[7].idx = 32'h0203_0000;
      run_tab[8].en = 4'b1000; run_tab[8].idx = 32'h0300_0000;

      rst   = 1'b1;
      start = 1'b0;
      k_len = '0;
`ifdef PE_ARRAY_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset", obs(), '0);
      rst = 1'b0;
      step();
      check("idle", obs(), '0);

      // K=4 table-driven run.
      begin_run(8'd4);
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) step();
         check($sformatf("k4 cyc%0d", c), obs(),
               pack(run_tab[c].busy, run_tab[c].pe_clr, run_tab[c].en,
                    run_tab[c].idx, run_tab[c].done, run_tab[c].done));
      end

      // K=0: CLEAR straight to DONE.
      begin_run(8'd0);
      check("k0 cyc1", obs(), pack(1'b1, 1'b1, '0, '0, 1'b0, 1'b0));
      step();
      check("k0 cyc2", obs(), pack(1'b1, 1'b0, '0, '0, 1'b1, 1'b1));
      step();
      check("k0 cyc3", obs(), '0);

      // start held high with K=1: 11-cycle period, one IDLE cycle between runs.
      k_len = 8'd1;
      start = 1'b1;
      step();
      for (int c = 1; c <= 44; c++) begin
         int p;
         logic [N-1:0] e;
         if (c > 1) step();
         if (c == 40) start = 1'b0;
         p = (c - 1) % 11;
         e = (p >= 1 && p <= 4) ? N'(1 << (p - 1)) : '0;
         check($sformatf("held cyc%0d", c), obs(),
               pack(p != 10, p == 0, e, '0, p == 9, p == 9));
      end

      // Reset in cycle 6 of a K=8 run, then restart immediately with K=2.
      begin_run(8'd8);
      repeat (5) step();
      check("rst pre cyc6", obs(), pack(1'b1, 1'b0, 4'b1111, 32'h0102_0304, 1'b0, 1'b0));
      rst = 1'b1;
      step();
      check("rst cyc7", obs(), '0);
      rst = 1'b0;
      begin_run(8'd2);
      check("rst restart cyc1", obs(), pack(1'b1, 1'b1, '0, '0, 1'b0, 1'b0));
      repeat (9) step();
      check("rst restart cyc10", obs(), pack(1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
      step();
      check("rst restart cyc11", obs(), pack(1'b1, 1'b0, '0, '0, 1'b1, 1'b1));
      step();
      check("rst restart cyc12", obs(), '0);

      // k_len changes to 9 mid-run and must be ignored.
      begin_run(8'd4);
      repeat (2) step();
      k_len = 8'd9;
      repeat (5) step();
      check("klen cyc8", obs(), pack(1'b1, 1'b0, 4'b1000, 32'h0300_0000, 1'b0, 1'b0));
      step();
      check("klen cyc9", obs(), pack(1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
      repeat (3) step();
      check("klen cyc12", obs(), pack(1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
      step();
      check("klen cyc13", obs(), pack(1'b1, 1'b0, '0, '0, 1'b1, 1'b1));
      step();
      check("klen cyc14", obs(), '0);

`ifdef PE_ARRAY_SEQ_ABORT_EN
      // Abort sampled in cycle 5 of a K=4 run.
      begin_run(8'd4);
      repeat (4) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort cyc6", {obs(), aborted}, {pack(1'b0, 1'b1, '0, '0, 1'b0, 1'b0), 1'b1});
      for (int c = 7; c <= 20; c++) begin
         step();
         check($sformatf("abort cyc%0d", c), {obs(), aborted}, '0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
- Sequencer for an N x N systolic array of PE_module-style processing elements.
- Each PE passes a/b operands to its neighbour through a register and accumulates the products.
- On start, this block:
  - clears the PE accumulators;
  - drives skewed per-lane read enables and k-indices to the A-row and B-column operand buffers;
  - waits for the pipeline to drain;
  - pulses done together with a result-capture strobe.
- Lane i feeds array row i (A side) and column i (B side) on the same schedule.

Parameters:
- N, 4, array dimension (number of row lanes = column lanes), 2..16.
- KW, 8, width of the k_len input and of each lane index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a matrix product; sampled only in IDLE.
- k_len  in  KW  inner dimension K; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- pe_clr  out  1  accumulator clear to all PEs.
- lane_en  out  N  bit i = lane i operand valid this cycle; the array injects 0 when low.
- lane_idx  out  N*KW  flattened; slice i = k index for lane i (bits i*KW +: KW).
- capture  out  1  result registers sample the PE outputs this cycle.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge, from any state):
  - state returns to IDLE;
  - busy=0, pe_clr=0, lane_en=0, lane_idx=0, capture=0, done=0;
  - internal counter=0 and latched K=0.
- States and transitions: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- Timing, with edge 0 = the edge at which start=1 is sampled in IDLE:
  - CLEAR, cycle 1:
    - pe_clr=1, busy=1;
    - K latched from k_len.
  - FEED, cycles 2..K+N:
    - feed counter t = 0..K+N-2;
    - lane i: lane_en[i]=1 iff i <= t <= i+K-1, with idx = t-i;
    - otherwise lane_en[i]=0 and idx=0.
  - DRAIN, cycles K+N+1..K+2N (N cycles):
    - lane_en=0;
    - covers N-1 cycles of operand propagation plus 1 accumulate.
  - DONE, cycle K+2N+1:
    - done=1, capture=1, busy=1;
    - next state is IDLE.
- Start-to-done latency is K+2N+1 cycles. For N=4, K=4 this is 13.
- pe_clr is high only in CLEAR.
- capture and done are high only in DONE.
- The t counter is KW+5 bits wide, so K+N-2 never overflows for any KW-bit K and N ≤ 16.
- Boundary conditions:
  - k_len=0: CLEAR -> DONE directly (no FEED, no DRAIN); done in cycle 2 with zero results.
  - k_len=all-ones: the schedule is unchanged; the index never exceeds K-1.
  - start while busy is ignored and not queued.
  - start held high continuously: the next accept is the edge after the DONE cycle, i.e. done falls as busy falls, and busy rises again 1 cycle later.
  - k_len changing while busy has no effect.
  - rst mid-operation: all outputs are zero at the next edge; no done pulse is produced.

Optional Feature:
- Macro: PE_ARRAY_SEQ_ABORT_EN.
- When defined, two extra ports are added: abort (in, 1) and aborted (out, 1).
- abort=1 sampled in CLEAR, FEED or DRAIN:
  - next cycle is IDLE with pe_clr=1 for that single cycle;
  - lane_en=0, busy=0;
  - aborted=1 for one cycle;
  - done and capture are never asserted for that operation.
- abort is ignored in IDLE and DONE.
- When the macro is undefined, the ports do not exist and behaviour is exactly as above.

Test Plan:
- N=4, k_len=4, start pulse at edge 0:
  - pe_clr high in cycle 1;
  - lane_en = 0001,0011,0111,1111,1110,1100,1000 over cycles 2..8;
  - lane 2 idx = 0,1,2,3 in cycles 4..7;
  - done=capture=1 in cycle 13 only;
  - busy high in cycles 1..13.
- k_len=0: pe_clr in cycle 1, done in cycle 2, lane_en never set.
- start held high for 40 cycles with k_len=1, N=4:
  - done pulses at cycles 10, 21 and 32;
  - pe_clr at cycles 1, 12 and 23;
  - no lane_en overlap between runs.
- rst asserted in cycle 6 of a k_len=8 run:
  - cycle 7 has all outputs 0;
  - no done;
  - a new start is accepted on the next edge.
- Change k_len from 4 to 9 in cycle 3 of a k_len=4 run: done still in cycle 13.
- With PE_ARRAY_SEQ_ABORT_EN, abort in cycle 5 of a k_len=4 run:
  - cycle 6 has pe_clr=1, aborted=1, busy=0;
  - no done through cycle 20.
